cnn_frame_sequencer: RTL and testbench
======================================

// Module: cnn_frame_sequencer
// PURPOSE
//  Frame scheduler in front of the CNN pipeline (conv1 -> pool1 -> conv2 -> pool2 -> fc).
//  Buffers one full input frame of ROWS parallel rows and streams it into conv layer 1 as a back-to-back burst with din_vald.
//  Then waits for the fc classification result before starting the next burst.
//  Loading of the next frame overlaps the wait for the current result. Result wait is bounded by a timeout.
// PARAMETERS
//  ROWS     26     rows per frame (conv1 ifmap height)
//  ROW_W    208    bits per row (26 px x 8 b)
//  TIMEOUT  65535  max cycles in WAIT for fc result; 16-bit counter, must be >= 1
// PORTS
//  clk             in   1      pipeline clock (PE clock domain)
//  rst_n           in   1      asynchronous reset, active low
//  en              in   1      global enable; low = freeze all state (no accept, no stream, no timeout count)
//  i_row_data      in   ROW_W  camera-side row
//  i_row_valid     in   1      row present on i_row_data
//  i_row_sof       in   1      qualifies i_row_valid: row is row 0 of a new frame
//  o_row_ready     out  1      sequencer accepts the row this cycle
//  o_ifmap_data    out  ROW_W  row to conv1 Ifmap_shift_in
//  o_ifmap_vald    out  1      conv1 din_vald
//  i_result_data   in   5      fc o_result_data
//  i_result_valid  in   1      fc o_result_data_valid (single-cycle pulse)
//  o_class         out  5      last classification, held until the next result
//  o_class_valid   out  1      1-cycle pulse when o_class updates
//  o_timeout       out  1      1-cycle pulse when a WAIT expires without result
//  o_busy          out  1      state != LOAD
//  o_frame_cnt     out  16     frames completed (result or timeout), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; state=LOAD, wr_cnt=0, rd_idx=0, timer=0. Reset mid-burst aborts the frame, buffer contents are discarded.
//  Buffer: ROWS x ROW_W registers; wr_cnt counts rows 0..ROWS. Buffer is "full" at wr_cnt==ROWS.
//  Accept: o_row_ready = en & (state!=STREAM) & (wr_cnt<ROWS), combinational. A write occurs when i_row_valid & o_row_ready.
//   Write with sof=1 stores at index 0 and sets wr_cnt=1, which resyncs a partial frame.
//   Write with sof=0 while wr_cnt==0 is dropped, and the row is still consumed (ready high).
//   Otherwise the row is stored at wr_cnt and wr_cnt is incremented.
//  States:
//   LOAD:   when wr_cnt==ROWS and en: -> STREAM, rd_idx=0.
//   STREAM: o_ifmap_vald=1, o_ifmap_data=buf[rd_idx], both registered, for each en-high cycle; rd_idx++.
//           en low: o_ifmap_vald=0, rd_idx held, which inserts a gap.
//           After rd_idx==ROWS-1 is issued: wr_cnt=0, timer=0, -> WAIT.
//           Exactly ROWS vald cycles per frame.
//   WAIT:   timer++ per en cycle. Loading of the next frame is allowed.
//           On i_result_valid: o_class<=i_result_data, o_class_valid pulse, o_frame_cnt++.
//             Then -> STREAM if the buffer is full (rd_idx=0), else -> LOAD.
//           If timer reaches TIMEOUT-1 without a result: o_timeout pulse, o_frame_cnt++, same next-state rule.
//           Result and timeout in the same cycle: result wins, no o_timeout.
//  i_result_valid in LOAD or STREAM: ignored, with no pulse.
//  Latency: last row accepted in cycle N, with en high -> first o_ifmap_vald in cycle N+2. N+1 is the LOAD->STREAM transition; the row register is loaded in N+1.
//  o_busy: registered from the next state.
// TESTING
//  1. Reset, then 26 rows with row k = {26{k[7:0]}}, sof on row 0 -> 26 consecutive vald cycles with data row 0..25 in order, starting 2 cycles after row 25; o_busy=1.
//  2. i_result_valid with data=5'd7 in WAIT -> o_class=7, one o_class_valid pulse, o_frame_cnt=1, state LOAD.
//  3. Second frame fully loaded during WAIT, then result -> STREAM the next cycle; o_row_ready=0 throughout the burst.
//  4. TIMEOUT=16 with no result -> o_timeout pulse exactly 16 cycles after the last vald; o_frame_cnt increments; result at the same cycle -> no timeout.
//  5. en low for 3 cycles at rd_idx=10 -> vald gap of 3, rows 10..25 resume unchanged; total vald count is 26.
//  6. sof at row 12 of a partial frame -> restart at index 0; rst_n low mid-STREAM -> vald=0 at once, and the next frame streams correctly.

Source files
------------

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the CNN pipeline: buffers one input frame of parallel rows and bursts it into conv1.
// It then waits for the fc result, with a timeout, while the next frame loads.
module cnn_frame_sequencer #(
    parameter int ROWS    = 26,
    parameter int ROW_W   = 208,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ROW_W-1:0] i_row_data,
    input  logic             i_row_valid,
    input  logic             i_row_sof,
    output logic             o_row_ready,
    output logic [ROW_W-1:0] o_ifmap_data,
    output logic             o_ifmap_vald,
    input  logic [4:0]       i_result_data,
    input  logic             i_result_valid,
    output logic [4:0]       o_class,
    output logic             o_class_valid,
    output logic             o_timeout,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt
);

    localparam int CW = $clog2(ROWS + 1);
    localparam int IW = $clog2(ROWS);
    localparam logic [CW-1:0] FULL_CNT = CW'(ROWS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);
    localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, STREAM, WAIT} state_t;

    state_t           state, state_next;
    logic [ROW_W-1:0] row_buf [ROWS];
    logic [CW-1:0]    wr_cnt;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx, rd_next, issue_idx;
    logic [15:0]      timer;
    logic             full, write_en, issue, stream_done, result_hit, timeout_hit;

    assign full        = (wr_cnt == FULL_CNT);
    assign o_row_ready = en && (state != STREAM) && (wr_cnt < FULL_CNT);
    assign write_en    = i_row_valid && o_row_ready;
    assign wr_idx      = i_row_sof ? '0 : wr_cnt[IW-1:0];

    // Frame storage needs no reset: wr_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (write_en && (i_row_sof || wr_cnt != '0))
            row_buf[wr_idx] <= i_row_data;
    end

    // rd_idx names the row issued next; entering STREAM issues row 0 in the same
    // cycle, so the burst starts the first STREAM cycle. Requires ROWS >= 2.
    always_comb begin
        state_next  = state;
        rd_next     = rd_idx;
        issue       = 1'b0;
        issue_idx   = rd_idx;
        stream_done = 1'b0;
        result_hit  = 1'b0;
        timeout_hit = 1'b0;
        if (en) begin
            case (state)
                LOAD: begin
                    if (full) begin
                        state_next = STREAM;
                        issue      = 1'b1;
                        issue_idx  = '0;
                        rd_next    = IW'(1);
                    end
                end
                STREAM: begin
                    issue = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        stream_done = 1'b1;
                        state_next  = WAIT;
                        rd_next     = '0;
                    end else begin
                        rd_next = rd_idx + IW'(1);
                    end
                end
                WAIT: begin
                    result_hit  = i_result_valid;
                    timeout_hit = !i_result_valid && (timer == TMO_LAST);
                    if (result_hit || timeout_hit) begin
                        if (full) begin
                            state_next = STREAM;
                            issue      = 1'b1;
                            issue_idx  = '0;
                            rd_next    = IW'(1);
                        end else begin
                            state_next = LOAD;
                        end
                    end
                end
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LOAD;
            rd_idx        <= '0;
            wr_cnt        <= '0;
            timer         <= '0;
            o_ifmap_vald  <= 1'b0;
            o_ifmap_data  <= '0;
            o_class       <= '0;
            o_class_valid <= 1'b0;
            o_timeout     <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            state  <= state_next;
            rd_idx <= rd_next;
            if (stream_done)
                wr_cnt <= '0;
            else if (write_en && i_row_sof)
                wr_cnt <= CW'(1);
            else if (write_en && wr_cnt != '0)
                wr_cnt <= wr_cnt + CW'(1);
            if (stream_done)
                timer <= '0;
            else if (en && state == WAIT)
                timer <= timer + 16'd1;
            o_ifmap_vald <= issue;
            if (issue)
                o_ifmap_data <= row_buf[issue_idx];
            o_class_valid <= result_hit;
            if (result_hit)
                o_class <= i_result_data;
            o_timeout <= timeout_hit;
            if (result_hit || timeout_hit)
                o_frame_cnt <= o_frame_cnt + 16'd1;
            o_busy <= (state_next != LOAD);
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: a long-timeout instance for bursts and results,
// and a TIMEOUT=16 instance sharing the row stimulus for the timeout behaviour.
module tb_cnn_frame_sequencer;

    localparam int ROWS  = 26;
    localparam int ROW_W = 208;
    localparam int TMO_M = 200;
    localparam int TMO_T = 16;

    logic             clk = 1'b0;
    logic             rst_n, en;
    logic [ROW_W-1:0] row_data;
    logic             row_valid, row_sof;
    logic [4:0]       res_data;
    logic             res_valid_m, res_valid_t;

    logic             m_ready, m_vald, m_class_valid, m_timeout, m_busy;
    logic [ROW_W-1:0] m_data;
    logic [4:0]       m_class;
    logic [15:0]      m_frame_cnt;
    logic             t_ready, t_vald, t_class_valid, t_timeout, t_busy;
    logic [ROW_W-1:0] t_data;
    logic [4:0]       t_class;
    logic [15:0]      t_frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_frame_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .TIMEOUT(TMO_M)) u_main (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i_row_data(row_data), .i_row_valid(row_valid), .i_row_sof(row_sof),
        .o_row_ready(m_ready), .o_ifmap_data(m_data), .o_ifmap_vald(m_vald),
        .i_result_data(res_data), .i_result_valid(res_valid_m),
        .o_class(m_class), .o_class_valid(m_class_valid), .o_timeout(m_timeout),
        .o_busy(m_busy), .o_frame_cnt(m_frame_cnt)
    );

    cnn_frame_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .TIMEOUT(TMO_T)) u_tmo (
        .clk(clk), .rst_n(rst_n), .en(en),
        .i_row_data(row_data), .i_row_valid(row_valid), .i_row_sof(row_sof),
        .o_row_ready(t_ready), .o_ifmap_data(t_data), .o_ifmap_vald(t_vald),
        .i_result_data(res_data), .i_result_valid(res_valid_t),
        .o_class(t_class), .o_class_valid(t_class_valid), .o_timeout(t_timeout),
        .o_busy(t_busy), .o_frame_cnt(t_frame_cnt)
    );

    function automatic logic [ROW_W-1:0] row_val(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {26{b}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic sof, input logic [ROW_W-1:0] data);
        row_valid = valid;
        row_sof   = sof;
        row_data  = data;
    endtask

    task automatic loadFrame(input int base);
        for (int k = 0; k < ROWS; k++) begin
            applyStimulus(1'b1, k == 0, row_val(base + k));
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic streamRows(input int base, input string tag, input bit chk_t);
        for (int i = 0; i < ROWS; i++) begin
            checkOutput($sformatf("%s_vald%0d", tag, i), m_vald, 1'b1);
            checkOutput($sformatf("%s_data%0d", tag, i), m_data, row_val(base + i));
            if (i < ROWS - 1)
                checkOutput($sformatf("%s_ready%0d", tag, i), m_ready, 1'b0);
            if (chk_t)
                checkOutput($sformatf("%s_tdata%0d", tag, i), t_data, row_val(base + i));
            tick();
        end
        checkOutput({tag, "_vald_end"}, m_vald, 1'b0);
    endtask

    // Entered in the cycle after the last row is accepted.
    task automatic checkBurst(input int base, input string tag, input bit chk_t);
        checkOutput({tag, "_vald_pre"}, m_vald, 1'b0);
        checkOutput({tag, "_ready_pre"}, m_ready, 1'b0);
        tick();
        streamRows(base, tag, chk_t);
    endtask

    task automatic sendResult(input logic [4:0] d);
        res_data    = d;
        res_valid_m = 1'b1;
        tick();
        res_valid_m = 1'b0;
    endtask

    initial begin
        int seen;
        logic exp_v;
        rst_n = 1'b0; en = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        res_data = '0; res_valid_m = 1'b0; res_valid_t = 1'b0;

        // Reset state
        tick(); tick();
        checkOutput("rst_vald", m_vald, 1'b0);
        checkOutput("rst_class_valid", m_class_valid, 1'b0);
        checkOutput("rst_timeout", m_timeout, 1'b0);
        checkOutput("rst_busy", m_busy, 1'b0);
        checkOutput("rst_frame_cnt", m_frame_cnt, 16'd0);
        checkOutput("rst_class", m_class, 5'd0);
        checkOutput("rst_ready", m_ready, 1'b0);
        rst_n = 1'b1; en = 1'b1;
        #1;
        checkOutput("load_ready", m_ready, 1'b1);
        checkOutput("load_ready_t", t_ready, 1'b1);

        // First frame: burst starts two cycles after the last row
        loadFrame(0);
        checkOutput("A_busy_pre", m_busy, 1'b0);
        checkBurst(0, "A", 1'b1);
        checkOutput("A_busy_wait", m_busy, 1'b1);

        // Timeout pulse 16 cycles after the last vald on the short-timeout instance
        repeat (14) tick();
        checkOutput("tmo_early", t_timeout, 1'b0);
        tick();
        checkOutput("tmo_pulse", t_timeout, 1'b1);
        checkOutput("tmo_frame_cnt", t_frame_cnt, 16'd1);
        checkOutput("tmo_busy", t_busy, 1'b0);
        checkOutput("tmo_main_none", m_timeout, 1'b0);
        checkOutput("tmo_main_cnt", m_frame_cnt, 16'd0);
        tick();
        checkOutput("tmo_single", t_timeout, 1'b0);

        // Result in WAIT on main; same pulse in LOAD is ignored by the other
        res_data = 5'd7; res_valid_m = 1'b1; res_valid_t = 1'b1;
        tick();
        res_valid_m = 1'b0; res_valid_t = 1'b0;
        checkOutput("res_class", m_class, 5'd7);
        checkOutput("res_class_valid", m_class_valid, 1'b1);
        checkOutput("res_frame_cnt", m_frame_cnt, 16'd1);
        checkOutput("res_busy", m_busy, 1'b0);
        checkOutput("ign_t_class_valid", t_class_valid, 1'b0);
        checkOutput("ign_t_class", t_class, 5'd0);
        checkOutput("ign_t_frame_cnt", t_frame_cnt, 16'd1);
        tick();
        checkOutput("res_pulse_end", m_class_valid, 1'b0);
        checkOutput("res_class_hold", m_class, 5'd7);
        sendResult(5'd3);
        checkOutput("ign_load_valid", m_class_valid, 1'b0);
        checkOutput("ign_load_class", m_class, 5'd7);
        checkOutput("ign_load_cnt", m_frame_cnt, 16'd1);

        // Second frame, then third loaded during WAIT; short instance gets result at its timeout cycle
        loadFrame(40);
        checkBurst(40, "B", 1'b1);
        res_data = 5'd21;
        for (int k = 0; k < ROWS; k++) begin
            applyStimulus(1'b1, k == 0, row_val(80 + k));
            res_valid_t = (k == 14);
            if (k == 0)
                checkOutput("wait_ready", m_ready, 1'b1);
            if (k == 15) begin
                checkOutput("tie_class_valid", t_class_valid, 1'b1);
                checkOutput("tie_no_timeout", t_timeout, 1'b0);
                checkOutput("tie_class", t_class, 5'd21);
                checkOutput("tie_frame_cnt", t_frame_cnt, 16'd2);
                checkOutput("tie_busy", t_busy, 1'b0);
            end
            if (k == 16)
                checkOutput("tie_late_timeout", t_timeout, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, '0);
        res_valid_t = 1'b0;
        checkOutput("full_wait_ready", m_ready, 1'b0);
        checkOutput("full_wait_vald", m_vald, 1'b0);
        checkOutput("full_wait_busy", m_busy, 1'b1);
        checkOutput("full_wait_tmo", m_timeout, 1'b0);
        sendResult(5'd12);
        checkOutput("C_class", m_class, 5'd12);
        checkOutput("C_class_valid", m_class_valid, 1'b1);
        checkOutput("C_frame_cnt", m_frame_cnt, 16'd2);
        checkOutput("C_busy", m_busy, 1'b1);
        streamRows(80, "C", 1'b0);
        sendResult(5'd2);
        checkOutput("C_done_cnt", m_frame_cnt, 16'd3);
        checkOutput("C_done_busy", m_busy, 1'b0);

        // en low for three cycles while row 10 is due
        loadFrame(120);
        checkOutput("G_vald_pre", m_vald, 1'b0);
        tick();
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            en    = !(c >= 9 && c <= 11);
            exp_v = (c <= 9) || (c >= 13 && c <= 28);
            checkOutput($sformatf("G_vald_c%0d", c), m_vald, exp_v);
            if (m_vald === 1'b1) begin
                checkOutput($sformatf("G_data%0d", seen), m_data, row_val(120 + seen));
                seen++;
            end
            tick();
        end
        en = 1'b1;
        checkOutput("G_total", seen, 26);
        sendResult(5'd9);
        checkOutput("G_done_cnt", m_frame_cnt, 16'd4);

        // sof on row 12 of a partial frame restarts at index 0
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, k == 0, row_val(160 + k));
            tick();
        end
        checkOutput("R_ready_partial", m_ready, 1'b1);
        loadFrame(200);
        checkBurst(200, "R", 1'b0);
        sendResult(5'd30);
        checkOutput("R_done_cnt", m_frame_cnt, 16'd5);
        checkOutput("R_class", m_class, 5'd30);

        // Reset in the middle of a burst
        loadFrame(60);
        repeat (5) tick();
        checkOutput("X_vald_mid", m_vald, 1'b1);
        checkOutput("X_data_mid", m_data, row_val(64));
        rst_n = 1'b0;
        #1;
        checkOutput("X_vald_rst", m_vald, 1'b0);
        checkOutput("X_busy_rst", m_busy, 1'b0);
        checkOutput("X_cnt_rst", m_frame_cnt, 16'd0);
        checkOutput("X_class_rst", m_class, 5'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checkOutput("X_vald_after", m_vald, 1'b0);
        loadFrame(90);
        checkBurst(90, "Y", 1'b0);
        checkOutput("Y_frame_cnt", m_frame_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
